// File: rtl/weight_load_ctrl.sv
// Weight tile loader between the per-column weight FIFOs and the systolic MMU.
// Tracks FIFO occupancy from push/pop strobes and pops columns with diagonal skew.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; start ignored in the cycle done is high
// S_WAIT  | start accepted, some column holds fewer than N weights
// S_LOAD  | phase t = 0..2N-2, column c pops while c <= t < c+N
// S_DRAIN | last column's final weight on the outputs; done follows
module weight_load_ctrl #(
  parameter int N          = 2,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N-1:0]        fifo_push,
  output logic [N-1:0]        fifo_pop,
  input  logic [N*DATA_W-1:0] fifo_data,
  output logic [N*DATA_W-1:0] weight_out,
  output logic [N-1:0]        weight_valid,
  output logic [N*ROW_W-1:0]  weight_row,
  output logic                busy,
  output logic                done,
  output logic                err_overflow
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int T_W   = $clog2(2 * N);
  localparam logic [T_W-1:0]   T_LAST   = T_W'(2 * N - 2);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_TILE = OCC_W'(N);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD, S_DRAIN} state_t;

  state_t           state;
  logic [T_W-1:0]   t;
  logic [OCC_W-1:0] occ [N];
  logic             all_full;

  always_comb begin
    all_full = 1'b1;
    for (int c = 0; c < N; c++)
      if (occ[c] < OCC_TILE) all_full = 1'b0;
  end

  // Diagonal skew: column c pops for N consecutive phases starting at t = c.
  always_comb begin
    fifo_pop = '0;
    for (int c = 0; c < N; c++)
      if (state == S_LOAD && int'(t) >= c && int'(t) < c + N) fifo_pop[c] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow <= 1'b0;
      for (int c = 0; c < N; c++) occ[c] <= '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        case ({fifo_push[c], fifo_pop[c]})
          2'b10: begin
            if (occ[c] == OCC_FULL) err_overflow <= 1'b1;
            else                    occ[c] <= occ[c] + 1'b1;
          end
          2'b01:   occ[c] <= occ[c] - 1'b1;
          default: occ[c] <= occ[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      t     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !done) begin
            busy  <= 1'b1;
            t     <= '0;
            state <= all_full ? S_LOAD : S_WAIT;
          end
        end
        S_WAIT: begin
          if (all_full) state <= S_LOAD;
        end
        S_LOAD: begin
          if (t == T_LAST) state <= S_DRAIN;
          else             t <= t + 1'b1;
        end
        S_DRAIN: begin
          state <= S_IDLE;
          t     <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The k-th pop of column c happens at t = c + k and targets row N-1-k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_valid <= '0;
      weight_row   <= '0;
    end else begin
      weight_valid <= fifo_pop;
      for (int c = 0; c < N; c++)
        weight_row[c*ROW_W +: ROW_W] <= fifo_pop[c] ? ROW_W'(N - 1 - (int'(t) - c)) : '0;
    end
  end

  // FIFO data arrives the cycle after the pop, aligned with weight_valid.
  always_comb begin
    weight_out = '0;
    for (int c = 0; c < N; c++)
      weight_out[c*DATA_W +: DATA_W] = weight_valid[c] ? fifo_data[c*DATA_W +: DATA_W] : '0;
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: behavioural column FIFOs plus a schedule model
// that predicts every output cycle by cycle from the start and load-entry cycles.
module tb_weight_load_ctrl;

  localparam int N          = 2;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int ROW_W      = (N > 1) ? $clog2(N) : 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [N-1:0]        fifo_push;
  logic [N-1:0]        fifo_pop;
  logic [N*DATA_W-1:0] fifo_data;
  logic [N*DATA_W-1:0] weight_out;
  logic [N-1:0]        weight_valid;
  logic [N*ROW_W-1:0]  weight_row;
  logic                busy;
  logic                done;
  logic                err_overflow;

  weight_load_ctrl #(.N(N), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fifo_push(fifo_push), .fifo_pop(fifo_pop),
    .fifo_data(fifo_data), .weight_out(weight_out), .weight_valid(weight_valid),
    .weight_row(weight_row), .busy(busy), .done(done), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Column FIFOs feeding the DUT (registered data_out, drops pushes when full).
  logic [DATA_W-1:0] push_data [N];
  logic [DATA_W-1:0] fq [N][$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) fq[c].delete();
      fifo_data <= '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (fifo_pop[c] && fq[c].size() > 0) begin
          fifo_data[c*DATA_W +: DATA_W] <= fq[c][0];
          void'(fq[c].pop_front());
        end
        if (fifo_push[c] && fq[c].size() < FIFO_DEPTH) fq[c].push_back(push_data[c]);
      end
    end
  end

  // Reference model: weights held per column in push order, plus sticky error.
  int mq [N][$];
  bit exp_err = 0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic tick(input logic [N-1:0] push, input logic st);
    fifo_push = push;
    start     = st;
    for (int c = 0; c < N; c++) begin
      push_data[c] = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      if (push[c]) begin
        if (mq[c].size() >= FIFO_DEPTH) exp_err = 1'b1;
        else                            mq[c].push_back(int'(push_data[c]));
      end
    end
    @(posedge clk);
    #1;
    fifo_push = '0;
    start     = 1'b0;
  endtask

  // S: cycle start was driven (-1 none). L: load-entry cycle (-1 not yet entered).
  task automatic chk(input int s, input int l);
    logic [N-1:0]        ep, ev;
    logic [N*DATA_W-1:0] ew;
    logic [N*ROW_W-1:0]  er;
    int rel, k;
    ep = '0; ev = '0; ew = '0; er = '0;
    rel = cyc - l;
    for (int c = 0; c < N; c++) begin
      k = rel - 1 - c;
      if (l >= 0 && rel >= c && rel < c + N) ep[c] = 1'b1;
      if (l >= 0 && k >= 0 && k < N) begin
        ev[c] = 1'b1;
        ew[c*DATA_W +: DATA_W] = DATA_W'(mq[c][k]);
        er[c*ROW_W +: ROW_W]   = ROW_W'(N - 1 - k);
      end
    end
    check("fifo_pop", fifo_pop, ep);
    check("weight_valid", weight_valid, ev);
    check("weight_out", weight_out, ew);
    check("weight_row", weight_row, er);
    check("busy", busy, (s >= 0 && cyc > s && (l < 0 || rel <= 2*N - 1)) ? 1 : 0);
    check("done", done, (l >= 0 && rel == 2*N) ? 1 : 0);
    check("err_overflow", err_overflow, exp_err);
  endtask

  task automatic chk_occ();
    for (int c = 0; c < N; c++) check("occ", dut.occ[c], mq[c].size());
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_pop"}, fifo_pop, 0);
    check({tag, "_valid"}, weight_valid, 0);
    check({tag, "_out"}, weight_out, 0);
    check({tag, "_row"}, weight_row, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err_overflow, 0);
  endtask

  task automatic fill_to(input int target);
    logic [N-1:0] p;
    bit ready;
    for (int i = 0; i < 6 * FIFO_DEPTH; i++) begin
      ready = 1;
      p = '0;
      for (int c = 0; c < N; c++)
        if (mq[c].size() < target) begin
          ready = 0;
          p[c] = 1'($urandom_range(0, 1));
        end
      if (ready) break;
      tick(p, 1'b0);
      chk(-1, -1);
    end
  endtask

  // Checks every cycle from load entry through one cycle past done.
  task automatic run_load(input int s, input int l, input bit push0_at_l, input bit hold_start);
    while (cyc <= l + 2*N + 1) begin
      chk(s, l);
      tick((push0_at_l && cyc == l) ? N'(1) : N'(0), hold_start && cyc <= l + 2*N);
    end
    chk(-1, -1);
    for (int c = 0; c < N; c++)
      for (int k = 0; k < N; k++) void'(mq[c].pop_front());
    chk_occ();
  endtask

  int s, l;

  initial begin
    rst_n = 1'b0; start = 1'b0; fifo_push = '0;
    for (int c = 0; c < N; c++) push_data[c] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk_occ();
    #3 rst_n = 1'b1;
    tick('0, 1'b0);
    chk(-1, -1);

    // Prefilled tile; start held high through done must not retrigger.
    fill_to(N);
    s = cyc; tick('0, 1'b1); l = cyc;
    run_load(s, l, 1'b0, 1'b1);

    // Push on col0 coinciding with its first pop leaves occupancy unchanged.
    fill_to(N);
    s = cyc; tick('0, 1'b1); l = cyc;
    run_load(s, l, 1'b1, 1'b0);

    // col1 one short: WAIT until the missing weight arrives.
    tick(2'b11, 1'b0);
    chk(-1, -1);
    s = cyc; tick('0, 1'b1);
    for (int i = 0; i < 3; i++) begin chk(s, -1); tick('0, 1'b0); end
    chk(s, -1);
    tick(2'b10, 1'b0);
    chk(s, -1);
    tick('0, 1'b0);
    l = cyc;
    run_load(s, l, 1'b0, 1'b0);

    // Overflow on col0, then the flag survives a completed load.
    while (!exp_err) begin tick(2'b01, 1'b0); chk(-1, -1); end
    chk_occ();
    fill_to(N);
    s = cyc; tick('0, 1'b1); l = cyc;
    run_load(s, l, 1'b0, 1'b0);

    // Randomized occupancy levels and data.
    for (int it = 0; it < 4; it++) begin
      fill_to($urandom_range(N, FIFO_DEPTH));
      fill_to(N);
      s = cyc; tick('0, 1'b1); l = cyc;
      run_load(s, l, 1'b0, it[0]);
    end

    // Reset during the third cycle of a load.
    fill_to(N);
    s = cyc; tick('0, 1'b1); l = cyc;
    chk(s, l); tick('0, 1'b0);
    chk(s, l); tick('0, 1'b0);
    #2 rst_n = 1'b0;
    for (int c = 0; c < N; c++) mq[c].delete();
    exp_err = 1'b0;
    #1 chk_zero("midreset");
    #3 rst_n = 1'b1;
    tick('0, 1'b0);
    chk(-1, -1);
    chk_occ();
    s = cyc; tick('0, 1'b1);
    for (int i = 0; i < 3; i++) begin chk(s, -1); tick('0, 1'b0); end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/weight_load_ctrl.md
Name: weight_load_ctrl

Overview:
- Sits directly downstream of the per-column weight FIFOs and upstream of the systolic MMU weight registers.
- Tracks each column FIFO's occupancy by monitoring its push strobes. On start, it waits until every column holds a full tile of N weights.
- It then pops the FIFOs with one-cycle-per-column diagonal skew and presents each byte to the MMU with valid and a target row index.
- The MMU controller uses it to implement en_load_weight sequencing.

Parameters:
- N, 2, array dimension: number of columns, and weights per column per tile.
- DATA_W, 8, weight width in bits.
- FIFO_DEPTH, 4, depth of each column FIFO. Must satisfy N <= FIFO_DEPTH.
- ROW_W, $clog2(N) (minimum 1), width of one row index.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to load one N x N weight tile.
- fifo_push  in  N  copy of each column FIFO's push strobe; occupancy monitor only.
- fifo_pop  out  N  pop strobe to each column FIFO.
- fifo_data  in  N*DATA_W  FIFO data_out buses, column c at bits [c*DATA_W +: DATA_W]. Valid the cycle after a pop.
- weight_out  out  N*DATA_W  weight byte per column, same packing as fifo_data.
- weight_valid  out  N  weight_out[c] is valid this cycle.
- weight_row  out  N*ROW_W  destination row for column c's current weight.
- busy  out  1  high from start acceptance through the DRAIN state.
- done  out  1  one-cycle pulse when a tile load completes.
- err_overflow  out  1  sticky: a push was seen on a column whose occupancy was already FIFO_DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All occupancy counters, phase counter, fifo_pop, weight_out, weight_valid, weight_row, busy, done and err_overflow are 0.
  - Reset mid-load aborts immediately. No done pulse. Occupancy returns to 0, and the FIFOs must be reset together with this block.
- Occupancy occ[c], width $clog2(FIFO_DEPTH+1), updated every cycle in all states:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - push while occ[c]==FIFO_DEPTH with no pop: occ unchanged, err_overflow set. err_overflow clears only on reset.
- State IDLE:
  - start=1 with all occ[c] >= N: go to LOAD next cycle, busy=1.
  - start=1 with any occ[c] < N: go to WAIT, busy=1.
  - start is ignored in every state except IDLE.
- State WAIT: go to LOAD the cycle after all occ[c] >= N (evaluated on registered counts).
- State LOAD:
  - Phase counter t runs 0..2N-2, one step per cycle.
  - fifo_pop[c] = 1 exactly when c <= t < c+N. fifo_pop is combinational from state and t, so it is asserted during the LOAD cycles themselves.
  - Popping is always legal because occupancy was guaranteed >= N before entry. No underflow path exists.
  - After t = 2N-2, go to DRAIN.
- State DRAIN:
  - One cycle; the last column's final weight is presented.
  - Next state IDLE, with done=1 for exactly that one cycle and busy=0.
- Output registers:
  - weight_valid[c] is the one-cycle-delayed fifo_pop[c].
  - weight_out[c] = fifo_data[c] in that same cycle, gated to 0 when not valid.
  - The k-th pop of column c (k = 0..N-1) gets weight_row[c] = N-1-k. The bottom row loads first.
  - weight_row is 0 when not valid.
- A start held high through done does not retrigger in the done cycle. It is sampled in IDLE only from the cycle after done.
- Latency:
  - Start accepted with data present to first weight_valid: 2 cycles.
  - Start to done: 2N+1 cycles.

Test Plan:
- Prefill (N=2): 2 pushes per column, then start at cycle 0.
  - fifo_pop = 01 (cycle 1), 11 (cycle 2), 10 (cycle 3).
  - weight_valid = 01 (cycle 2), 11 (cycle 3), 10 (cycle 4).
  - Rows: col0 = 1 then 0; col1 = 1 then 0.
  - done=1 at cycle 5. Data order matches push order.
- Start with col1 holding only 1 weight: busy=1, state WAIT, no pops. Push col1 once, then LOAD starts the next cycle and the same pop/valid pattern follows.
- Push on col0 during LOAD, simultaneous with its pop: occ[0] unchanged. After done, occ[0]==1 (began at 2).
- Push 5 times into col0 with no pops: occ[0]==4, err_overflow=1 and stays 1 after a completed load.
- Assert rst_n=0 at cycle 3 of a load: all outputs 0 immediately. After release, start with no data goes to WAIT.
- start pulses during LOAD/DRAIN are ignored: exactly one done, and exactly 2N pops per column.
